// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Holds two N x N signed operand matrices (A and B) and, on start, streams
//   them onto the west (a_edge) and north (b_edge) edges of an N x N systolic
//   multiply array with the diagonal skew the PEs need: row i of A is delayed
//   i cycles, column j of B is delayed j cycles.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   wr_en/wr_sel        write strobe, target matrix (0 = A, 1 = B)
//   wr_row/wr_col       element index, out-of-range writes are dropped
//   wr_data             signed element value
//   start               single-cycle feed request, honoured only in IDLE
//   busy                FSM not IDLE
//   done                one-cycle pulse after the last feed step
//   feed_valid          edge buses carry step feed_step
//   a_edge/b_edge       lane k occupies bits [k*DW +: DW]
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = (N > 1) ? $clog2(N) : 1,
    parameter int SW = $clog2(3 * N - 2)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_row,
    input  logic [AW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            feed_valid,
    output logic [SW-1:0]   feed_step,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FEED   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [SW-1:0] LAST_STEP = SW'(3 * N - 3);

    logic [1:0]    state;
    logic [SW-1:0] t;

    logic [DW-1:0] mem_a [N][N];
    logic [DW-1:0] mem_b [N][N];

    logic [N*DW-1:0] a_next;
    logic [N*DW-1:0] b_next;
    int              d;

    assign busy = (state != IDLE);

    // Step t contents: lane k carries the element whose diagonal index t-k
    // falls inside the matrix; everything else is a zero bubble.
    always_comb begin
        a_next = '0;
        b_next = '0;
        d      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            d = int'(t) - int'(k);
            if (d >= 0 && d < N) begin
                a_next[k*DW +: DW] = mem_a[k][d[AW-1:0]];
                b_next[k*DW +: DW] = mem_b[d[AW-1:0]][k];
            end
        end
    end

    // Operand storage; writes only land while idle so a feed always sees a
    // stable matrix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    mem_a[r][c] <= '0;
                    mem_b[r][c] <= '0;
                end
            end
        end else if (state == IDLE && wr_en &&
                     int'(wr_row) < N && int'(wr_col) < N) begin
            if (wr_sel) begin
                mem_b[wr_row][wr_col] <= wr_data;
            end else begin
                mem_a[wr_row][wr_col] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            t          <= '0;
            done       <= 1'b0;
            feed_valid <= 1'b0;
            feed_step  <= '0;
            a_edge     <= '0;
            b_edge     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FEED;
                        t     <= '0;
                    end
                end
                FEED: begin
                    a_edge     <= a_next;
                    b_edge     <= b_next;
                    feed_valid <= 1'b1;
                    feed_step  <= t;
                    t          <= t + SW'(1);
                    if (t == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    a_edge     <= '0;
                    b_edge     <= '0;
                    feed_valid <= 1'b0;
                    feed_step  <= '0;
                    t          <= '0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
//   Directed bench for systolic_feeder (N = 4, DW = 16) with a small
//   behavioural 4x4 output-stationary PE array hung off the edge buses.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int SW = 4;

    logic            clk;
    logic            reset_n;
    logic            wr_en;
    logic            wr_sel;
    logic [AW-1:0]   wr_row;
    logic [AW-1:0]   wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            feed_valid;
    logic [SW-1:0]   feed_step;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_a [10];
    logic [63:0] cap_b [10];
    int          valid_cnt;
    int          done_cnt;
    int          done_k;

    int ma [4][4];
    int mb [4][4];

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .feed_valid (feed_valid),
        .feed_step  (feed_step),
        .a_edge     (a_edge),
        .b_edge     (b_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural output-stationary PE array: a moves east, b moves south.
    logic signed [15:0] pa  [4][4];
    logic signed [15:0] pb  [4][4];
    int                 acc [4][4];
    logic signed [15:0] ai, bi;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= 0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == 0) ai = a_edge[i*16 +: 16];
                    else        ai = pa[i][j-1];
                    if (i == 0) bi = b_edge[j*16 +: 16];
                    else        bi = pb[i-1][j];
                    pa[i][j]  <= ai;
                    pb[i][j]  <= bi;
                    acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input logic [15:0] v);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = r[1:0];
        wr_col  = c[1:0];
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic start_feed();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_e0", {63'd0, busy}, 64'd1);
    endtask

    // Entered just after E0. k counts negedges, so k = n samples after En.
    task automatic capture(input bit poke, input bit stop);
        int k;
        bit fin;
        for (int s = 0; s < 10; s++) begin
            cap_a[s] = '1;
            cap_b[s] = '1;
        end
        valid_cnt = 0;
        done_cnt  = 0;
        done_k    = -1;
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            wr_en = 1'b0;
            if (feed_valid) begin
                if (feed_step < 10) begin
                    cap_a[feed_step] = a_edge;
                    cap_b[feed_step] = b_edge;
                end
                check("step_seq", 64'(feed_step), 64'(valid_cnt));
                valid_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (poke && (k == 3 || k == 10)) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 2'd1;
                wr_col  = 2'd1;
                wr_data = 16'd99;
            end
            if (done_k >= 0 && (stop || k >= done_k + 3)) fin = 1'b1;
            if (k >= 40) begin
                check("done_timeout", 64'd0, 64'd1);
                fin = 1'b1;
            end
        end
    endtask

    function automatic logic [63:0] exp_a(input int t);
        logic [63:0] v;
        logic [15:0] e;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (t - i >= 0 && t - i < 4) begin
                e = 16'(ma[i][t-i]);
                v[i*16 +: 16] = e;
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_b(input int t);
        logic [63:0] v;
        logic [15:0] e;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            if (t - j >= 0 && t - j < 4) begin
                e = 16'(mb[t-j][j]);
                v[j*16 +: 16] = e;
            end
        end
        return v;
    endfunction

    initial begin
        logic [63:0] any;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        start   = 1'b0;

        #3;
        check("rst_a", a_edge, 64'd0);
        check("rst_b", b_edge, 64'd0);
        check("rst_ctl", {57'd0, busy, done, feed_valid, feed_step}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // A[r][c] = 4r+c+1, B = identity
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 4 * r + c + 1;
                mb[r][c] = (r == c) ? 1 : 0;
                wr(1'b0, r, c, 16'(ma[r][c]));
                wr(1'b1, r, c, 16'(mb[r][c]));
            end
        end

        start_feed();
        capture(1'b0, 1'b0);
        check("s0_a", cap_a[0], 64'h0000_0000_0000_0001);
        check("s0_b", cap_b[0], 64'h0000_0000_0000_0001);
        check("s3_a", cap_a[3], 64'h000D_000A_0007_0004);
        check("s3_b", cap_b[3], 64'h0000_0000_0000_0000);
        check("s6_a", cap_a[6], 64'h0010_0000_0000_0000);
        check("s6_b", cap_b[6], 64'h0001_0000_0000_0000);
        check("s9_a", cap_a[9], 64'h0);
        check("s9_b", cap_b[9], 64'h0);
        check("valid_cnt", 64'(valid_cnt), 64'd10);
        check("done_cnt", 64'(done_cnt), 64'd1);
        check("done_k", 64'(done_k), 64'd11);
        check("idle_after", {63'd0, busy}, 64'd0);
        for (int t = 0; t < 10; t++) begin
            check("model_a", cap_a[t], exp_a(t));
            check("model_b", cap_b[t], exp_b(t));
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                check("pe_acc", 64'(acc[i][j]), 64'(4 * i + j + 1));
            end
        end

        // start + write pokes during FEED and FINISH are ignored
        start_feed();
        capture(1'b1, 1'b0);
        check("poke_done_cnt", 64'(done_cnt), 64'd1);
        check("poke_done_k", 64'(done_k), 64'd11);
        check("poke_valid", 64'(valid_cnt), 64'd10);

        // replay shows old A[1][1]; start on the done cycle is accepted
        start_feed();
        capture(1'b0, 1'b1);
        check("replay_a11", {48'd0, cap_a[2][31:16]}, 64'd6);
        check("replay_done_k", 64'(done_k), 64'd11);
        start_feed();
        capture(1'b0, 1'b0);
        check("restart_done_k", 64'(done_k), 64'd11);
        check("restart_valid", 64'(valid_cnt), 64'd10);
        check("restart_a11", {48'd0, cap_a[2][31:16]}, 64'd6);

        // write together with start is included in the feed
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 2'd1;
        wr_col  = 2'd1;
        wr_data = 16'd99;
        start_feed();
        capture(1'b0, 1'b0);
        check("wr_start_a11", {48'd0, cap_a[2][31:16]}, 64'd99);

        // signed extremes pass bit-exact
        wr(1'b0, 0, 0, 16'h8000);
        wr(1'b1, 0, 0, 16'h7FFF);
        start_feed();
        capture(1'b0, 1'b0);
        check("ext_a", {48'd0, cap_a[0][15:0]}, 64'h8000);
        check("ext_b", {48'd0, cap_b[0][15:0]}, 64'h7FFF);

        // asynchronous reset mid-feed
        start_feed();
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_a", a_edge, 64'd0);
        check("midrst_b", b_edge, 64'd0);
        check("midrst_ctl", {57'd0, busy, done, feed_valid, feed_step}, 64'd0);
        @(negedge clk);
        check("midrst_nodone", {63'd0, done}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        start_feed();
        capture(1'b0, 1'b0);
        any = '0;
        for (int s = 0; s < 10; s++) any = any | cap_a[s] | cap_b[s];
        check("postrst_zero", any, 64'd0);
        check("postrst_done_k", 64'(done_k), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
